// File: rtl/dm_load_responder_pkg.sv
// Shared definitions for the data-memory load/store responder:
// instruction codes, exception codes, FSM states and load-type decode.
package dm_load_responder_pkg;

    // MIPS opcodes for the memory instructions handled by the MEM stage
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    localparam int DM_DEPTH_DEFAULT = 3072;

    typedef enum logic [0:0] {
        DM_ST_CLEAR = 1'b0,
        DM_ST_RUN   = 1'b1
    } dm_state_e;

    typedef enum logic [2:0] {
        LT_W, LT_H, LT_HU, LT_B, LT_BU
    } load_type_e;

    function automatic logic is_store(input logic [5:0] op);
        return op inside {OP_SW, OP_SH, OP_SB};
    endfunction

    function automatic logic is_load(input logic [5:0] op);
        return op inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
    endfunction

    function automatic load_type_e load_type(input logic [5:0] op);
        load_type_e lt;
        case (op)
            OP_LH:   lt = LT_H;
            OP_LHU:  lt = LT_HU;
            OP_LB:   lt = LT_B;
            OP_LBU:  lt = LT_BU;
            default: lt = LT_W;
        endcase
        return lt;
    endfunction

endpackage

// File: rtl/dm_load_responder_if.sv
// MEM-stage request/response bundle between the pipeline and the data memory.
interface dm_load_responder_if;
    logic        req_valid;
    logic [5:0]  mem_instr;
    logic [31:0] addr;
    logic [3:0]  byte_en;
    logic [31:0] wdata;
    logic        stall;
    logic        ready;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic [4:0]  exc_code;

    modport master (
        output req_valid, mem_instr, addr, byte_en, wdata, stall,
        input  ready, rdata, rdata_valid, exc_code
    );

    modport slave (
        input  req_valid, mem_instr, addr, byte_en, wdata, stall,
        output ready, rdata, rdata_valid, exc_code
    );
endinterface

// File: rtl/dm_load_responder_load_extend.sv
// Lane extraction and sign/zero extension of a captured memory word.
module dm_load_responder_load_extend
    import dm_load_responder_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  load_type_e  type_i,
    output logic [31:0] data_o
);
    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/half and extend it according to the load type
    always_comb begin
        shifted  = word_i >> {off_i, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
        case (type_i)
            LT_H:    data_o = {{16{half_sel[15]}}, half_sel};
            LT_HU:   data_o = {16'h0000, half_sel};
            LT_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            LT_BU:   data_o = {24'h000000, byte_sel};
            default: data_o = word_i;
        endcase
    end
endmodule

// File: rtl/dm_load_responder.sv
// Data-memory endpoint for the MEM stage: byte-masked stores, registered loads
// with 1-cycle latency, and a clear engine that zeroes the array after reset.
// Optional build macro DM_MISALIGN_CHECK_EN turns misaligned and out-of-range
// accesses into AdEL/AdES exceptions instead of proceeding silently.
module dm_load_responder
    import dm_load_responder_pkg::*;
#(
    parameter int DEPTH = DM_DEPTH_DEFAULT,
    parameter int AW    = 12
) (
    input  logic               clk,
    input  logic               reset,
    dm_load_responder_if.slave bus
);
    dm_state_e     state_q, state_d;
    logic [AW-1:0] clear_ptr_q, clear_ptr_d;
    logic          clr_we;
    logic          ready;

    logic          accept, op_store, op_load, out_of_range;
    logic          ld_exc, st_exc, st_we, ld_cap;
    logic [4:0]    exc_d;
    logic [AW-1:0] idx;

    logic [1:0]    off_q;
    load_type_e    type_q;
    logic          rdata_valid_q;
    logic [4:0]    exc_q;
    logic [31:0]   word_rd;

    assign idx = bus.addr[AW+1:2];

    // State register for the clear/run controller
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= DM_ST_CLEAR;
            clear_ptr_q <= '0;
        end else begin
            state_q     <= state_d;
            clear_ptr_q <= clear_ptr_d;
        end
    end

    // Walk the clear pointer across the array once, then stay in RUN
    always_comb begin
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        clr_we      = 1'b0;
        ready       = 1'b0;
        case (state_q)
            DM_ST_CLEAR: begin
                clr_we      = 1'b1;
                clear_ptr_d = clear_ptr_q + 1'b1;
                if (clear_ptr_q == AW'(DEPTH - 1)) begin
                    state_d     = DM_ST_RUN;
                    clear_ptr_d = '0;
                end
            end
            DM_ST_RUN: ready = 1'b1;
            default:   state_d = DM_ST_CLEAR;
        endcase
    end

    // Decode the request; the upper address bits count toward range so that
    // aliases beyond the array never hit a real word
    always_comb begin
        op_store     = is_store(bus.mem_instr);
        op_load      = is_load(bus.mem_instr);
        accept       = bus.req_valid && ready && !bus.stall;
        out_of_range = (bus.addr[31:2] >= 30'(DEPTH));
        ld_exc       = 1'b0;
        st_exc       = 1'b0;
`ifdef DM_MISALIGN_CHECK_EN
        ld_exc = op_load && (out_of_range
                 || (bus.mem_instr == OP_LW && bus.addr[1:0] != 2'b00)
                 || ((bus.mem_instr == OP_LH || bus.mem_instr == OP_LHU) && bus.addr[0]));
        st_exc = op_store && (out_of_range
                 || (bus.mem_instr == OP_SW && bus.addr[1:0] != 2'b00)
                 || (bus.mem_instr == OP_SH && bus.addr[0]));
`endif
        exc_d  = ld_exc ? EXC_ADEL : (st_exc ? EXC_ADES : EXC_NONE);
        st_we  = accept && op_store && !out_of_range && !st_exc && !reset;
        ld_cap = accept && op_load && !ld_exc;
    end

    // One byte-wide array per lane so each byte_en bit maps to its own write enable
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem_q [DEPTH];
            logic [7:0] rd_q;

            // Clear engine has the port during CLEAR; masked stores use it in RUN
            always_ff @(posedge clk) begin
                if (clr_we) begin
                    mem_q[clear_ptr_q] <= 8'h00;
                end else if (st_we && bus.byte_en[gi]) begin
                    mem_q[idx] <= bus.wdata[8*gi +: 8];
                end
            end

            // Registered read, only on an accepted load; out-of-range reads as zero
            always_ff @(posedge clk) begin
                if (reset) begin
                    rd_q <= 8'h00;
                end else if (ld_cap) begin
                    rd_q <= out_of_range ? 8'h00 : mem_q[idx];
                end
            end

            assign word_rd[8*gi +: 8] = rd_q;
        end
    endgenerate

    // Response registers: frozen by stall, cleared when nothing is accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_valid_q <= 1'b0;
            exc_q         <= EXC_NONE;
            off_q         <= 2'b00;
            type_q        <= LT_W;
        end else if (!bus.stall) begin
            rdata_valid_q <= ld_cap;
            exc_q         <= accept ? exc_d : EXC_NONE;
            if (ld_cap) begin
                off_q  <= bus.addr[1:0];
                type_q <= load_type(bus.mem_instr);
            end
        end
    end

    dm_load_responder_load_extend u_ext (
        .word_i (word_rd),
        .off_i  (off_q),
        .type_i (type_q),
        .data_o (bus.rdata)
    );

    assign bus.ready       = ready;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.exc_code    = exc_q;

endmodule
